// File: rtl/memory_fill_pkg.sv
// Shared types and constants for the memory_fill range writer.
package memory_fill_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_CONST   = 2'd0,
    MODE_ADDR    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_LFSR    = 2'd3
  } mode_e;

  // Right-shifting Galois toggle mask for x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  localparam logic [63:0] CHK_EVEN = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] CHK_ODD  = 64'h5555_5555_5555_5555;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'd0);
  endfunction

endpackage

// File: rtl/memory_fill_pattern.sv
// Combinational pattern generator and LFSR next/seed logic, shared by the write and read passes.
// Zero latency, no flow control.
module memory_fill_pattern
  import memory_fill_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
) (
  input  logic [1:0]        mode_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       lfsr_i,
  input  logic [DATA_W-1:0] fill_i,
  output logic [DATA_W-1:0] pattern_o,
  output logic [31:0]       lfsr_next_o,
  output logic [31:0]       seed_o
);

  logic [63:0] fill_ext;

  assign fill_ext    = 64'(fill_i);
  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  assign seed_o      = (fill_ext[31:0] == 32'd0) ? 32'd1 : fill_ext[31:0];
  assign lfsr_next_o = lfsr_step(lfsr_i);

  always_comb begin
    pattern_o = '0;
    case (mode_i)
      MODE_CONST:   pattern_o = fill_i;
      MODE_ADDR:    pattern_o = DATA_W'(addr_i);
      MODE_CHECKER: pattern_o = addr_i[0] ? DATA_W'(CHK_ODD) : DATA_W'(CHK_EVEN);
      default:      pattern_o = DATA_W'({lfsr_i, lfsr_i});
    endcase
  end

endmodule

// File: rtl/memory_fill.sv
// Range fill engine: one pattern word per unpaused cycle, first wren one cycle after the enable edge;
// pause stalls new requests only. Define MEMORY_FILL_VERIFY_EN for the read-back verify pass.
module memory_fill
  import memory_fill_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              pause,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [DATA_W-1:0] data_read,
  output logic              wren,
  output logic              rden,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_write,
  output logic              busy,
  output logic              done,
  output logic              range_err,
  output logic [15:0]       err_count
);

  state_e            state_q, state_d;
  logic              enable_q;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] end_q;
  logic [DATA_W-1:0] fill_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic              range_err_q, range_err_d;

  logic              start_evt, last_word, issue;
  logic [DATA_W-1:0] pat_fill, pat_word;
  logic [31:0]       lfsr_next, lfsr_seed;

  assign start_evt = (state_q == ST_IDLE) && enable && !enable_q;
  assign last_word = (addr_q == end_q);
  assign issue     = ((state_q == ST_WRITE) || (state_q == ST_READ)) && !pause;
  // The seed comes from the live input at the start edge, from the latched copy for the reload.
  assign pat_fill  = (state_q == ST_IDLE) ? fill_value : fill_q;

  memory_fill_pattern #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pattern (
    .mode_i      (mode_q),
    .addr_i      (addr_q),
    .lfsr_i      (lfsr_q),
    .fill_i      (pat_fill),
    .pattern_o   (pat_word),
    .lfsr_next_o (lfsr_next),
    .seed_o      (lfsr_seed)
  );

`ifdef MEMORY_FILL_VERIFY_EN
  logic [ADDR_W-1:0] start_q;
  logic [RD_LAT-1:0] pipe_vld_q;
  logic [DATA_W-1:0] pipe_dat_q [RD_LAT];
  logic [15:0]       err_q, err_d;
  logic              drain_ok, miss;

  // Leave DRAIN as the final return is being compared, so done follows it by one cycle.
  always_comb begin
    drain_ok = 1'b1;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      if (pipe_vld_q[i]) drain_ok = 1'b0;
    end
  end

  assign miss = pipe_vld_q[RD_LAT-1] && (pipe_dat_q[RD_LAT-1] != data_read);

  always_comb begin
    err_d = err_q;
    if (!enable) err_d = '0;
    else if (miss && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q    <= '0;
      pipe_vld_q <= '0;
      err_q      <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_dat_q[i] <= '0;
    end else begin
      err_q <= err_d;
      if (start_evt) start_q <= start_addr;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1] && enable;
        pipe_dat_q[i] <= pipe_dat_q[i-1];
      end
      pipe_vld_q[0] <= rden && enable;
      pipe_dat_q[0] <= pat_word;
    end
  end

  assign err_count = err_q;
`else
  logic unused_rd;
  assign unused_rd = ^data_read;
  assign err_count = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start_evt) state_d = (end_addr < start_addr) ? ST_DONE : ST_WRITE;
`ifdef MEMORY_FILL_VERIFY_EN
        ST_WRITE: if (issue && last_word) state_d = ST_READ;
        ST_READ:  if (issue && last_word) state_d = ST_DRAIN;
        ST_DRAIN: if (drain_ok) state_d = ST_DONE;
`else
        ST_WRITE: if (issue && last_word) state_d = ST_DONE;
`endif
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wren       = 1'b0;
    rden       = 1'b0;
    address    = '0;
    data_write = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_WRITE: begin
        busy       = 1'b1;
        wren       = !pause;
        address    = addr_q;
        data_write = pat_word;
      end
`ifdef MEMORY_FILL_VERIFY_EN
      ST_READ: begin
        busy    = 1'b1;
        rden    = !pause;
        address = addr_q;
      end
      ST_DRAIN: busy = 1'b1;
`endif
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign range_err = range_err_q;

  always_comb begin
    addr_d      = addr_q;
    lfsr_d      = lfsr_q;
    range_err_d = range_err_q;
    if (!enable) begin
      addr_d      = '0;
      lfsr_d      = '0;
      range_err_d = 1'b0;
    end else if (start_evt) begin
      addr_d      = start_addr;
      lfsr_d      = lfsr_seed;
      range_err_d = (end_addr < start_addr);
    end else if (issue) begin
      // The end compare stops the sweep, so a full-range run never wraps the address.
      if (!last_word) begin
        addr_d = addr_q + ADDR_W'(1);
        lfsr_d = lfsr_next;
      end
`ifdef MEMORY_FILL_VERIFY_EN
      else if (state_q == ST_WRITE) begin
        addr_d = start_q;
        lfsr_d = lfsr_seed;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q    <= 1'b0;
      mode_q      <= '0;
      end_q       <= '0;
      fill_q      <= '0;
      addr_q      <= '0;
      lfsr_q      <= '0;
      range_err_q <= 1'b0;
    end else begin
      enable_q    <= enable;
      addr_q      <= addr_d;
      lfsr_q      <= lfsr_d;
      range_err_q <= range_err_d;
      if (start_evt) begin
        mode_q <= mode;
        end_q  <= end_addr;
        fill_q <= fill_value;
      end
    end
  end

endmodule

// File: tb/tb_memory_fill.sv
// Directed bench for memory_fill with a pattern/scoreboard model and per-cycle write checking.
module tb_memory_fill;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              pause = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic [DATA_W-1:0] fill_value = '0;
  logic [DATA_W-1:0] data_read = '0;
  logic              wren, rden, busy, done, range_err;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_write;
  logic [15:0]       err_count;

  memory_fill #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pause(pause), .mode(mode),
    .start_addr(start_addr), .end_addr(end_addr), .fill_value(fill_value),
    .data_read(data_read), .wren(wren), .rden(rden), .address(address),
    .data_write(data_write), .busy(busy), .done(done), .range_err(range_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int          vecs = 0;
  int          miscompares = 0;
  logic        chk_on = 1'b0;
  logic        corrupt_en = 1'b0;
  logic [7:0]  exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] cap_q[$];
  logic [31:0] mem [256];
  logic [31:0] rd_s1 = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'd0);
  endfunction

  function automatic logic [31:0] model_word(input logic [1:0] m, input int a,
                                             input logic [31:0] f, input logic [31:0] lf);
    case (m)
      2'd0:    return f;
      2'd1:    return 32'(a);
      2'd2:    return (a % 2 == 1) ? 32'h5555_5555 : 32'hAAAA_AAAA;
      default: return lf;
    endcase
  endfunction

  function automatic int exp_done(input int n, input int p);
`ifdef MEMORY_FILL_VERIFY_EN
    return 2 * n + p + RD_LAT + 1;
`else
    return n + p + 1;
`endif
  endfunction

  // Memory model: stores written words, returns reads RD_LAT cycles later, optionally corrupting 3 and 6.
  always @(posedge clk) begin
    if (wren) mem[address] <= data_write;
    rd_s1     <= rden ? (mem[address] ^ ((corrupt_en && (address == 8'd3 || address == 8'd6)) ? 32'h100 : 32'h0)) : 32'h0;
    data_read <= rd_s1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      if (wren) begin
        if (exp_addr_q.size() == 0) begin
          check("unexpected_wren", {56'd0, address}, 64'hFFFF);
        end else begin
          check("wr_addr", {56'd0, address}, {56'd0, exp_addr_q.pop_front()});
          check("wr_data", {32'd0, data_write}, {32'd0, exp_data_q.pop_front()});
          cap_q.push_back(data_write);
        end
      end
`ifndef MEMORY_FILL_VERIFY_EN
      check("verify_outputs_off", {47'd0, rden, err_count}, 64'd0);
`endif
    end
  end

  task automatic load(input logic [1:0] m, input int s, input int e, input logic [31:0] f, input int nmax);
    logic [31:0] lf;
    int a, k;
    lf = (f == 32'd0) ? 32'd1 : f;
    mode = m; start_addr = ADDR_W'(s); end_addr = ADDR_W'(e); fill_value = f;
    exp_addr_q.delete(); exp_data_q.delete(); cap_q.delete();
    a = s; k = 0;
    while (a <= e && k < nmax) begin
      exp_addr_q.push_back(8'(a));
      exp_data_q.push_back(model_word(m, a, f, lf));
      lf = lfsr_next(lf);
      a++; k++;
    end
  endtask

  task automatic run(input string nm, input int exp_cyc, input int p_from, input int p_len,
                     input int exp_err, input logic exp_rerr);
    int cyc, done_cyc;
    cyc = 0; done_cyc = -1;
    @(posedge clk); #1; enable = 1'b1;
    while (done_cyc < 0 && cyc < 2000) begin
      @(posedge clk); #1; cyc++;
      pause = (cyc >= p_from && cyc < p_from + p_len);
      if (cyc == 1) begin
        mode = ~mode; fill_value = ~fill_value; start_addr = ~start_addr; end_addr = ~end_addr;
      end
      @(negedge clk);
      if (done) done_cyc = cyc;
    end
    pause = 1'b0;
    check({nm, "_done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
    check({nm, "_writes_missing"}, 64'(exp_addr_q.size()), 64'd0);
    check({nm, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    check({nm, "_range_err"}, {63'd0, range_err}, {63'd0, exp_rerr});
    check({nm, "_err_count"}, {48'd0, err_count}, 64'(exp_err));
    @(posedge clk); #1;
    @(negedge clk);
    check({nm, "_done_held"}, {63'd0, done}, 64'd1);
    @(posedge clk); #1; enable = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check({nm, "_cleared"}, {45'd0, done, range_err, busy, err_count}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {wren, rden, address, data_write, busy, done, range_err, err_count}, 64'd0);
    #1 reset_n = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    check("idle_outputs", {wren, rden, address, data_write, busy, done, range_err, err_count}, 64'd0);

    load(2'd0, 'h10, 'h13, 32'hDEAD_BEEF, 1000);
    run("const", exp_done(4, 0), 0, 0, 0, 1'b0);
    check("const_word0", 64'(cap_q[0]), 64'hDEAD_BEEF);
    check("const_word3", 64'(cap_q[3]), 64'hDEAD_BEEF);

    load(2'd2, 0, 3, 32'h0, 1000);
    run("checker_pause", exp_done(4, 3), 2, 3, 0, 1'b0);
    check("checker_word0", 64'(cap_q[0]), 64'hAAAA_AAAA);
    check("checker_word1", 64'(cap_q[1]), 64'h5555_5555);

    load(2'd3, 0, 5, 32'h0, 1000);
    run("lfsr_seed0", exp_done(6, 0), 0, 0, 0, 1'b0);
    check("lfsr0_word0", 64'(cap_q[0]), 64'h0000_0001);
    check("lfsr0_word1", 64'(cap_q[1]), 64'h8020_0003);
    check("lfsr0_word2", 64'(cap_q[2]), 64'hC030_0002);
    check("lfsr0_word3", 64'(cap_q[3]), 64'h6018_0001);

    load(2'd3, 0, 5, 32'h1, 1000);
    run("lfsr_seed1", exp_done(6, 0), 0, 0, 0, 1'b0);
    check("lfsr1_word0", 64'(cap_q[0]), 64'h0000_0001);
    check("lfsr1_word3", 64'(cap_q[3]), 64'h6018_0001);

    load(2'd1, 5, 4, 32'h0, 1000);
    run("range_err", 1, 0, 0, 0, 1'b1);

    load(2'd2, 7, 7, 32'h0, 1000);
    run("single", exp_done(1, 0), 0, 0, 0, 1'b0);
    check("single_word0", 64'(cap_q[0]), 64'h5555_5555);

    load(2'd1, 'h3C, 'h4F, 32'h0, 5);
    @(posedge clk); #1; enable = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
    end
    check("abort_addr_before_drop", {56'd0, address}, 64'h40);
    enable = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_next_cycle", {wren, address, done, busy}, 64'd0);
    check("abort_writes_missing", 64'(exp_addr_q.size()), 64'd0);
    load(2'd1, 'h3C, 'h4F, 32'h0, 1000);
    run("restart", exp_done(20, 0), 0, 0, 0, 1'b0);
    check("restart_word0", 64'(cap_q[0]), 64'h3C);

    load(2'd1, 0, 255, 32'h0, 1000);
    run("full_range", exp_done(256, 0), 0, 0, 0, 1'b0);
    check("full_last_word", 64'(cap_q[255]), 64'hFF);

    corrupt_en = 1'b1;
    load(2'd1, 0, 7, 32'h0, 1000);
`ifdef MEMORY_FILL_VERIFY_EN
    run("verify", exp_done(8, 0), 0, 0, 2, 1'b0);
`else
    run("verify", exp_done(8, 0), 0, 0, 0, 1'b0);
`endif
    corrupt_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
